// File: rtl/or_stim_gen_if.sv
// rtl/or_stim_gen_if.sv - control and stimulus bundle between the OR-gate stimulus sequencer and its consumer.
interface or_stim_gen_if #(
  parameter int WIDTH = 2,
  parameter int CW    = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] stim;
  logic             stim_valid;
  logic             busy;
  logic             done;
  logic [CW-1:0]    vec_count;

  modport master (
    input  start,
    input  abort,
    output stim,
    output stim_valid,
    output busy,
    output done,
    output vec_count
  );

  modport slave (
    output start,
    output abort,
    input  stim,
    input  stim_valid,
    input  busy,
    input  done,
    input  vec_count
  );
endinterface

// File: rtl/or_stim_gen.sv
// rtl/or_stim_gen.sv - clocked vector sequencer for the OR-gate checker (LFSR source).
// Define OR_STIM_SWEEP_EN to replace the LFSR with an exhaustive WIDTH-bit up-counter.
module or_stim_gen #(
  parameter int          WIDTH       = 2,
  parameter int          NUM_VECTORS = 10,
  parameter int          HOLD_CYCLES = 5,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  or_stim_gen_if.master bus
);
  localparam int CW = $clog2(NUM_VECTORS + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef OR_STIM_SWEEP_EN
  localparam int GW = WIDTH;
`else
  localparam int GW = 16;
`endif

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("or_stim_gen: WIDTH must be 1..16");
  end
  if (NUM_VECTORS < 1) begin : g_bad_num
    $error("or_stim_gen: NUM_VECTORS must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("or_stim_gen: HOLD_CYCLES must be >= 1");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("or_stim_gen: SEED must be nonzero");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_stim, w_stim_n;
  logic             r_valid, w_valid_n;
  logic [CW-1:0]    r_vc, w_vc_n;
  logic [HW-1:0]    r_hold, w_hold_n;
  logic [GW-1:0]    r_gen, w_gen_n;
  logic [GW-1:0]    w_gen_step;
  logic [WIDTH-1:0] w_vec;
  logic             w_issue;

`ifdef OR_STIM_SWEEP_EN
  // Counter value is issued first, then advances, so the sweep starts at 0.
  assign w_gen_step = r_gen + 1'b1;
  assign w_vec      = r_gen;
`else
  assign w_gen_step = r_gen[0] ? ((r_gen >> 1) ^ 16'hB400) : (r_gen >> 1);
  assign w_vec      = w_gen_step[WIDTH-1:0];
`endif

  always_comb begin
    w_state_n = r_state;
    w_stim_n  = r_stim;
    w_valid_n = 1'b0;
    w_vc_n    = r_vc;
    w_hold_n  = r_hold;
    w_gen_n   = r_gen;
    w_issue   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.abort) begin
          w_state_n = S_IDLE;
        end else if (bus.start) begin
          w_state_n = S_RUN;
          w_issue   = 1'b1;
          w_vc_n    = CW'(1);
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_n = S_IDLE;
        end else if (r_hold != '0) begin
          w_hold_n = r_hold - 1'b1;
        end else if (r_vc < CW'(NUM_VECTORS)) begin
          w_issue = 1'b1;
          w_vc_n  = r_vc + 1'b1;
        end else begin
          w_state_n = S_DONE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_issue) begin
      w_stim_n  = w_vec;
      w_gen_n   = w_gen_step;
      w_valid_n = 1'b1;
      w_hold_n  = HW'(HOLD_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stim  <= '0;
      r_valid <= 1'b0;
      r_vc    <= '0;
      r_hold  <= '0;
`ifdef OR_STIM_SWEEP_EN
      r_gen   <= '0;
`else
      r_gen   <= SEED;
`endif
    end else begin
      r_state <= w_state_n;
      r_stim  <= w_stim_n;
      r_valid <= w_valid_n;
      r_vc    <= w_vc_n;
      r_hold  <= w_hold_n;
      r_gen   <= w_gen_n;
    end
  end

  assign bus.stim       = r_stim;
  assign bus.stim_valid = r_valid;
  assign bus.busy       = (r_state == S_RUN);
  assign bus.done       = (r_state == S_DONE);
  assign bus.vec_count  = r_vc;
endmodule

// File: tb/tb_or_stim_gen.sv
// tb/tb_or_stim_gen.sv - scoreboard bench for or_stim_gen (LFSR or OR_STIM_SWEEP_EN build).
module tb_or_stim_gen;
`ifdef OR_STIM_SWEEP_EN
  localparam int NV = 6;
  localparam int H  = 1;
`else
  localparam int NV = 10;
  localparam int H  = 5;
`endif
  localparam int          W    = 2;
  localparam int          CW   = $clog2(NV + 1);
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  or_stim_gen_if #(.WIDTH(W), .CW(CW)) bus ();

  or_stim_gen #(.WIDTH(W), .NUM_VECTORS(NV), .HOLD_CYCLES(H), .SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] stim;
    int           vc;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         m_e;
  int           checks = 0;
  int           failures = 0;
  logic [15:0]  m_gen;
  logic [W-1:0] last_stim;
  int           cs;
  int           na;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] sh;
    sh = {1'b0, s[15:1]};
    return s[0] ? (sh ^ 16'hB400) : sh;
  endfunction

  function automatic logic [15:0] model_reset();
`ifdef OR_STIM_SWEEP_EN
    return 16'h0000;
`else
    return SEED;
`endif
  endfunction

  // Expected vectors for a run of n issues starting on the next clock edge.
  task automatic push_run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
`ifdef OR_STIM_SWEEP_EN
      e.stim = m_gen[W-1:0];
      m_gen  = (m_gen + 16'd1) & 16'((1 << W) - 1);
`else
      m_gen  = lfsr_next(m_gen);
      e.stim = m_gen[W-1:0];
`endif
      e.vc  = i + 1;
      e.cyc = cyc + 1 + i * H;
      sb.push_back(e);
      last_stim = e.stim;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_done(input int lim);
    while (bus.done !== 1'b1 && cyc < lim) tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.stim_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_stim_valid", {31'd0, bus.stim_valid}, 32'd0);
      end else begin
        m_e = sb.pop_front();
        chk("vec_stim", 32'(bus.stim), 32'(m_e.stim));
        chk("vec_count", 32'(bus.vec_count), m_e.vc);
        chk("vec_cycle", cyc, m_e.cyc);
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    m_gen = model_reset();
    repeat (3) tick();
    chk("rst_stim", 32'(bus.stim), 0);
    chk("rst_valid", 32'(bus.stim_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_vc", 32'(bus.vec_count), 0);
    rst_n = 1'b1;
    tick();

    // Full run with a single-cycle start pulse
    cs = cyc;
    push_run(NV);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("first_stim", 32'(bus.stim), 0);
    chk("first_busy", 32'(bus.busy), 1);
    chk("first_vc", 32'(bus.vec_count), 1);
    repeat (4) begin
      tick();
      chk("hold_valid", 32'(bus.stim_valid), (H == 1) ? 1 : 0);
    end
    wait_done(cs + NV * H + 20);
    chk("done_cycle", cyc, cs + 1 + NV * H);
    chk("done_level", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_vc", 32'(bus.vec_count), NV);
    chk("done_stim", 32'(bus.stim), 32'(last_stim));
    repeat (3) tick();
    chk("done_stim_held", 32'(bus.stim), 32'(last_stim));
    chk("done_still", 32'(bus.done), 1);
    chk("run1_all_seen", sb.size(), 0);

    // Abort two cycles after the third vector strobe
    na = 3 + 2 / H;
    cs = cyc;
    push_run(na);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < cs + 3 + 2 * H) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_vc", 32'(bus.vec_count), na);
    chk("abort_stim", 32'(bus.stim), 32'(last_stim));
    chk("abort_valid", 32'(bus.stim_valid), 0);
    repeat (2 * H + 2) tick();
    chk("abort_vc_held", 32'(bus.vec_count), na);
    chk("abort_idle", 32'(bus.busy), 0);

    // Restart without reseed, start held high through the run
    cs = cyc;
    push_run(NV);
    bus.start = 1'b1;
    while (cyc < cs + NV * H) tick();
    bus.start = 1'b0;
    wait_done(cs + NV * H + 20);
    chk("done2_cycle", cyc, cs + 1 + NV * H);
    chk("done2_vc", 32'(bus.vec_count), NV);
    chk("done2_stim", 32'(bus.stim), 32'(last_stim));

    // start and abort together in DONE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_done", 32'(bus.done), 0);
    chk("sa_busy", 32'(bus.busy), 0);
    chk("sa_vc", 32'(bus.vec_count), NV);
    repeat (H + 2) tick();
    chk("sa_stays_idle", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of a hold
    push_run(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stim", 32'(bus.stim), 0);
    chk("arst_valid", 32'(bus.stim_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_vc", 32'(bus.vec_count), 0);
    m_gen = model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    push_run(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("post_rst_stim", 32'(bus.stim), 0);
    chk("post_rst_vc", 32'(bus.vec_count), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (3) tick();
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
